// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A-compatible interrupt datapath.
// Holds the INTA state encoding, OCW2 command codes and the priority-rank helper.
package pic_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACK1  = 3'd1,
        WAIT1 = 3'd2,
        WAIT2 = 3'd3,
        ACK2  = 3'd4
    } state_t;

    // OCW2 bits [7:5] = {R, SL, EOI}
    localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] OCW2_NOP          = 3'b010;
    localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
    localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
    localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

    localparam logic [2:0] LP_RESET_DEF   = 3'd7;
    localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;

    // Rank 0 is the highest priority: the level just after the lowest-priority pointer.
    function automatic logic [2:0] prio_rank(input logic [2:0] level, input logic [2:0] lp);
        return level - lp - 3'd1;
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating priority resolver: highest-priority request and highest-priority in-service level.
// Purely combinational; priority starts at lp+1 and wraps through lp.
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [7:0] req,
    input  logic [7:0] isr_vec,
    input  logic [2:0] lp,
    output logic       req_valid,
    output logic [2:0] req_level,
    output logic       isr_valid,
    output logic [2:0] isr_level
);

    logic [2:0] idx;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        req_valid = 1'b0;
        req_level = SPURIOUS_LEVEL;
        isr_valid = 1'b0;
        isr_level = 3'd0;
        idx       = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            idx = lp + 3'd1 + 3'(k);
            if (req[idx]) begin
                req_valid = 1'b1;
                req_level = idx;
            end
            if (isr_vec[idx]) begin
                isr_valid = 1'b1;
                isr_level = idx;
            end
        end
    end

endmodule

// File: rtl/pic_irq_core.sv
// 8259A interrupt datapath: IR/INTA synchronizers, IRR/ISR/IMR, rotating priority,
// 8086-mode two-pulse INTA sequencing and OCW2 EOI/rotate execution.
module pic_irq_core
    import pic_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [2:0] LP_RESET    = LP_RESET_DEF
) (
    input  logic       CLK,
    input  logic       _RST,
    input  logic [7:0] IR,
    input  logic       _INTA,
    input  logic       CFG_WR,
    input  logic       CFG_LTIM,
    input  logic [4:0] CFG_BASE,
    input  logic       CFG_AEOI,
    input  logic       IMR_WR,
    input  logic [7:0] IMR_DATA,
    input  logic       OCW2_WR,
    input  logic [7:0] OCW2_DATA,
    output logic       INT,
    output logic [7:0] DOUT,
    output logic       DOUT_EN,
    output logic [7:0] IRR,
    output logic [7:0] ISR,
    output logic [7:0] IMR,
    output state_t     DBG_STATE
);

    logic [7:0]             ir_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] inta_sync;
    logic [7:0]             ir_d;
    logic                   inta_d;
    logic [7:0]             ir_s;
    logic                   inta_s;
    logic [7:0]             ir_rise;
    logic                   inta_fall;
    logic                   inta_rise;

    state_t     state;
    logic [2:0] lp;
    logic       rot_aeoi;
    logic [2:0] vec;
    logic       spurious;

    logic [7:0] irr_n;
    logic [7:0] isr_n;
    logic [2:0] lp_n;
    logic       rot_aeoi_n;
    logic       int_n;

    logic       req_valid;
    logic [2:0] req_level;
    logic       isr_valid;
    logic [2:0] isr_level;

    logic [2:0] ocw2_cmd;
    logic [2:0] ocw2_lvl;
    logic       unused_ocw2;

    assign ocw2_cmd    = OCW2_DATA[7:5];
    assign ocw2_lvl    = OCW2_DATA[2:0];
    assign unused_ocw2 = ^OCW2_DATA[4:3];

    assign ir_s      = ir_sync[SYNC_STAGES-1];
    assign inta_s    = inta_sync[SYNC_STAGES-1];
    assign ir_rise   = ir_s & ~ir_d;
    assign inta_fall = ~inta_s & inta_d;
    assign inta_rise = inta_s & ~inta_d;
    assign DBG_STATE = state;

    // Synchronizers plus one extra flop for edge detection; CFG_WR clears them like reset.
    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) ir_sync[i] <= '0;
            inta_sync <= '0;
            ir_d      <= '0;
            inta_d    <= 1'b0;
        end else if (CFG_WR) begin
            for (int i = 0; i < SYNC_STAGES; i++) ir_sync[i] <= '0;
            inta_sync <= '0;
            ir_d      <= '0;
            inta_d    <= 1'b0;
        end else begin
            ir_sync[0] <= IR;
            for (int i = 1; i < SYNC_STAGES; i++) ir_sync[i] <= ir_sync[i-1];
            inta_sync <= {inta_sync[SYNC_STAGES-2:0], _INTA};
            ir_d      <= ir_s;
            inta_d    <= inta_s;
        end
    end

    pic_priority_resolver u_resolver (
        .req       (IRR & ~IMR),
        .isr_vec   (ISR),
        .lp        (lp),
        .req_valid (req_valid),
        .req_level (req_level),
        .isr_valid (isr_valid),
        .isr_level (isr_level)
    );

    // Fully nested: only a strictly higher-ranked request than every in-service level interrupts.
    always_comb begin
        int_n = 1'b0;
        if (state != ACK1 && req_valid) begin
            if (!isr_valid)
                int_n = 1'b1;
            else if (prio_rank(req_level, lp) < prio_rank(isr_level, lp))
                int_n = 1'b1;
        end
    end

    // Register updates are layered: INTA effects first, then OCW2 (which sees the current ISR).
    always_comb begin
        irr_n      = CFG_LTIM ? ir_s : ((IRR | ir_rise) & ir_s);
        isr_n      = ISR;
        lp_n       = lp;
        rot_aeoi_n = rot_aeoi;

        if (state == ACK1 && req_valid) begin
            irr_n[req_level] = 1'b0;
            isr_n[req_level] = 1'b1;
        end

        if (state == ACK2 && inta_rise && CFG_AEOI && !spurious) begin
            isr_n[vec] = 1'b0;
            if (rot_aeoi)
                lp_n = vec;
        end

        if (OCW2_WR) begin
            case (ocw2_cmd)
                OCW2_NS_EOI: begin
                    if (isr_valid)
                        isr_n[isr_level] = 1'b0;
                end
                OCW2_SP_EOI: begin
                    if (ISR[ocw2_lvl])
                        isr_n[ocw2_lvl] = 1'b0;
                end
                OCW2_ROT_NS_EOI: begin
                    if (isr_valid) begin
                        isr_n[isr_level] = 1'b0;
                        lp_n             = isr_level;
                    end
                end
                OCW2_ROT_SP_EOI: begin
                    if (ISR[ocw2_lvl]) begin
                        isr_n[ocw2_lvl] = 1'b0;
                        lp_n            = ocw2_lvl;
                    end
                end
                OCW2_SET_PRIO:     lp_n       = ocw2_lvl;
                OCW2_ROT_AEOI_SET: rot_aeoi_n = 1'b1;
                OCW2_ROT_AEOI_CLR: rot_aeoi_n = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            IRR      <= '0;
            ISR      <= '0;
            IMR      <= '0;
            lp       <= LP_RESET;
            rot_aeoi <= 1'b0;
        end else if (CFG_WR) begin
            IRR      <= '0;
            ISR      <= '0;
            IMR      <= '0;
            lp       <= LP_RESET;
            rot_aeoi <= 1'b0;
        end else begin
            IRR      <= irr_n;
            ISR      <= isr_n;
            lp       <= lp_n;
            rot_aeoi <= rot_aeoi_n;
            if (IMR_WR)
                IMR <= IMR_DATA;
        end
    end

    // INTA sequencer; the vector level is frozen in ACK1 so later IR/ISR activity cannot alter it.
    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state    <= IDLE;
            INT      <= 1'b0;
            DOUT     <= '0;
            DOUT_EN  <= 1'b0;
            vec      <= '0;
            spurious <= 1'b0;
        end else if (CFG_WR) begin
            state    <= IDLE;
            INT      <= 1'b0;
            DOUT     <= '0;
            DOUT_EN  <= 1'b0;
            vec      <= '0;
            spurious <= 1'b0;
        end else begin
            INT <= int_n;
            case (state)
                IDLE: begin
                    if (inta_fall)
                        state <= ACK1;
                end
                ACK1: begin
                    vec      <= req_valid ? req_level : SPURIOUS_LEVEL;
                    spurious <= !req_valid;
                    state    <= WAIT1;
                end
                WAIT1: begin
                    if (inta_rise)
                        state <= WAIT2;
                end
                WAIT2: begin
                    if (inta_fall) begin
                        DOUT    <= {CFG_BASE, vec};
                        DOUT_EN <= 1'b1;
                        state   <= ACK2;
                    end
                end
                ACK2: begin
                    if (inta_rise) begin
                        DOUT_EN <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/pic_irq_core.md
Name: pic_irq_core

Overview:
- Interrupt datapath stage of the 8259A-compatible PIC, directly downstream of the control unit that decodes ICW/OCW writes.
- Captures IR0–IR7 into the Interrupt Request Register (IRR), applies the Interrupt Mask Register (IMR) and a rotating priority resolver, and raises INT.
- Runs the 8086-mode two-pulse INTA sequence that sets the In-Service Register (ISR) and drives the vector {base, level}.
- Executes OCW2 EOI and rotate commands.

Parameters:
- SYNC_STAGES, 2, flops in the IR and _INTA synchronizers (min 2).
- LP_RESET, 3'd7, lowest-priority pointer after reset or CFG_WR (IR0 highest).

Ports:
- CLK  in  1  system clock; all state on rising edge.
- _RST  in  1  asynchronous, active-low reset.
- IR  in  8  raw interrupt request pins, asynchronous.
- _INTA  in  1  raw interrupt acknowledge, active low, asynchronous.
- CFG_WR  in  1  one-cycle pulse: ICW1 accepted; reinitialise.
- CFG_LTIM  in  1  1 = level-triggered, 0 = edge-triggered.
- CFG_BASE  in  5  vector base, T7..T3 from ICW2.
- CFG_AEOI  in  1  automatic EOI (ICW4 bit 1).
- IMR_WR  in  1  one-cycle pulse: load IMR (OCW1).
- IMR_DATA  in  8  new mask; 1 = masked.
- OCW2_WR  in  1  one-cycle pulse: execute OCW2.
- OCW2_DATA  in  8  bits [7:5] = R,SL,EOI; bits [2:0] = level L.
- INT  out  1  interrupt to CPU, registered.
- DOUT  out  8  vector byte.
- DOUT_EN  out  1  drive DATA bus with DOUT.
- IRR  out  8  current IRR, for the OCW3 read path.
- ISR  out  8  current ISR.
- IMR  out  8  current mask.

Behaviour:
- Reset (async, _RST low): IRR = ISR = IMR = 0; LP = LP_RESET; rotate-AEOI flag = 0; state IDLE; INT = 0; DOUT = 0; DOUT_EN = 0; synchronizers cleared.
- CFG_WR: same effect as reset, but synchronous. It aborts any INTA sequence (state → IDLE, DOUT_EN = 0). It overrides IMR_WR and OCW2_WR in the same cycle.
- Synchronizers: IR and _INTA each pass through SYNC_STAGES flops. Edge detectors run on the synchronized values.
- IRR, level mode: IRR[i] = synced IR[i] each cycle, except bits frozen by ACK1.
- IRR, edge mode: IRR[i] set on a synced rising edge; cleared when synced IR[i] is low, or by ACK1 for the acknowledged level.
  - An edge in the same cycle as its ACK1 clear is lost; the next rising edge re-arms it.
- Latency: IR pin rise → IRR bit after SYNC_STAGES+1 edges → INT one edge later (4 edges at default).
- Priority order starts at (LP+1) mod 8 and wraps through LP. The resolver finds the highest-priority bit of IRR & ~IMR and the highest-priority bit of ISR.
- INT (next-cycle register) = 1 when the unmasked request outranks every ISR bit (fully nested). An equal or lower request never asserts INT.
- State machine, with transitions on synced _INTA edges:
  - IDLE → ACK1 on a falling edge.
  - ACK1 (one cycle):
    - Latch the winning level V.
    - Set ISR[V] and clear IRR[V].
    - INT → 0.
    - If there is no valid request: V = 7, ISR unchanged (spurious).
    - Then → WAIT1.
  - WAIT1 → WAIT2 on a rising edge.
  - WAIT2 → ACK2 on a falling edge.
  - ACK2: DOUT = {CFG_BASE, V}, DOUT_EN = 1. On a rising edge:
    - DOUT_EN → 0.
    - If CFG_AEOI and not spurious, clear ISR[V].
    - If the rotate-AEOI flag is also set, LP = V.
    - Then → IDLE.
- The first INTA pulse never drives DOUT_EN.
- OCW2 on OCW2_WR, decoded from bits [7:5]:
  - 001: nonspecific EOI, clears the highest-priority ISR bit.
  - 011: specific EOI, clears ISR[L].
  - 101: rotate on nonspecific EOI; clears the highest-priority ISR bit h, then LP = h.
  - 111: rotate on specific EOI; ISR[L] cleared, LP = L.
  - 110: set priority, LP = L.
  - 100 / 000: set / clear the rotate-AEOI flag.
  - 010: no-op.
- OCW2 boundary cases:
  - EOI with ISR empty, or specific EOI on a clear bit: no ISR change; rotate variants leave LP unchanged.
  - OCW2 is legal during an INTA sequence and takes effect immediately. If it clears ISR[V] before ACK2, the vector is still {base, V}.
- IMR_WR loads IMR next edge. Masking an active level drops INT next cycle; it does not abort a sequence already in ACK1 or later.
- IR changes after ACK1 do not alter V or DOUT.

Decomposition:
- Package pic_pkg: state enum (IDLE, ACK1, WAIT1, WAIT2, ACK2), OCW2 command encodings, LP_RESET default, SPURIOUS_LEVEL = 3'd7.
- One sub-module, pic_priority_resolver (combinational): inputs request vector, ISR, LP; outputs valid, winning level, highest ISR level, isr_valid.

Test Plan:
- Edge mode, IMR = 0, base = 5'b01000: pulse IR3 high → INT after 4 edges. INTA×2 → DOUT = 0x43 with DOUT_EN only in pulse 2; ISR = 0x08, IRR = 0x00.
- Nesting: IR5 in service, raise IR6 → INT stays 0. Raise IR2 → INT = 1, ACK → ISR = 0x24. Nonspecific EOI → ISR = 0x20.
- Mask: IMR = 0x10, raise IR4 → INT stays 0. IMR = 0x00 → INT = 1 one edge after the write.
- Spurious: raise IR1 then drop it before INTA, INTA×2 → DOUT = {base, 3'b111}, ISR = 0x00.
- Rotate: ISR = 0x08, OCW2 = 0xA0 → ISR = 0x00, LP = 3. Raise IR3 and IR4 together → vector level 4.
- AEOI + reset: CFG_AEOI = 1, ack IR0 → ISR = 0 after pulse 2. Assert _RST during WAIT2 → DOUT_EN = 0, INT = 0, all registers 0 immediately.
